// File: rtl/adc_demap_serializer_pkg.sv
// Shared constants, FSM state type and helpers for the ADC demap serializer.
// Covers channel reversal and the saturating drop counter.
package adc_demap_serializer_pkg;

    localparam int CH_NUM  = 32;
    localparam int CH_WD   = 16;
    localparam int DATA_WD = CH_NUM * CH_WD;
    localparam int HEAD_WD = 64;
    localparam int OUT_WD  = 128;
    localparam int NW      = DATA_WD / OUT_WD;
    localparam int KW      = $clog2(NW);
    localparam int OVF_W   = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Maps ch[i] to ch[CH_NUM-1-i].
    function automatic logic [DATA_WD-1:0] reverse_ch(input logic [DATA_WD-1:0] beat);
        logic [DATA_WD-1:0] r;
        r = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            r[CH_WD*i +: CH_WD] = beat[CH_WD*(CH_NUM-1-i) +: CH_WD];
        end
        return r;
    endfunction

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (&v) ? v : v + OVF_W'(1);
    endfunction

endpackage

// File: rtl/adc_demap_serializer_if.sv
// Beat input and word output stream of the ADC demap serializer.
// The slave modport is the serializer's view; the master modport is the environment's view.
interface adc_demap_serializer_if;
    import adc_demap_serializer_pkg::*;

    logic               dmap_ivld;
    logic [DATA_WD-1:0] dmap_idat;
    logic [HEAD_WD-1:0] enc_idat;
    logic               dmap_ovld;
    logic               dmap_ordy;
    logic [OUT_WD-1:0]  dmap_odat;
    logic               dmap_osop;
    logic               dmap_oeop;
    logic [HEAD_WD-1:0] enc_odat;

    modport slave (
        input  dmap_ivld, dmap_idat, enc_idat, dmap_ordy,
        output dmap_ovld, dmap_odat, dmap_osop, dmap_oeop, enc_odat
    );

    modport master (
        output dmap_ivld, dmap_idat, enc_idat, dmap_ordy,
        input  dmap_ovld, dmap_odat, dmap_osop, dmap_oeop, enc_odat
    );

endinterface

// File: rtl/adc_demap_serializer_sync.sv
// Multi-flop bit synchronizer for quasi-static control bits from another clock domain.
module cmip_bit_sync_imp #(
    parameter int DATA_WDTH = 1,
    parameter int BUS_DELAY = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_WDTH-1:0] din_i,
    output logic [DATA_WDTH-1:0] dout_o
);

    logic [DATA_WDTH-1:0] sync_q [BUS_DELAY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUS_DELAY; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= din_i;
            for (int i = 1; i < BUS_DELAY; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign dout_o = sync_q[BUS_DELAY-1];

endmodule

// File: rtl/adc_demap_serializer.sv
// Receives 512-bit ADC beats with header, optionally reverses channel order, buffers two
// beats and serializes each into NW output words on a valid/ready stream.
module adc_demap_serializer
    import adc_demap_serializer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_rst,
    input  logic             demap_en,
    adc_demap_serializer_if.slave bus,
    output logic [OVF_W-1:0] ovf_cnt
);

    logic demap_sync;

    cmip_bit_sync_imp #(
        .DATA_WDTH (1),
        .BUS_DELAY (3)
    ) u_demap_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (demap_en),
        .dout_o (demap_sync)
    );

    logic [DATA_WD-1:0] beat_mem_q [2];
    logic [HEAD_WD-1:0] hdr_mem_q  [2];

    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [KW-1:0]    k_q, k_d;
    state_e           state_q, state_d;
    logic [OVF_W-1:0] ovf_q, ovf_d;

    logic               hs, pop, wr, drop, ovld;
    logic [DATA_WD-1:0] wr_beat, head_beat;

    // Order is chosen once per beat at write time, so a beat never mixes orders.
    assign wr_beat   = demap_sync ? reverse_ch(bus.dmap_idat) : bus.dmap_idat;
    assign head_beat = beat_mem_q[rd_ptr_q];

    assign ovld = (cnt_q != 2'd0);
    assign hs   = ovld && bus.dmap_ordy;
    assign pop  = hs && (k_q == KW'(NW-1));
    assign wr   = bus.dmap_ivld && ((cnt_q != 2'd2) || pop);
    assign drop = bus.dmap_ivld && !wr;

    assign bus.dmap_ovld = ovld;
    assign bus.dmap_odat = ovld ? head_beat[OUT_WD*k_q +: OUT_WD] : '0;
    assign bus.dmap_osop = ovld && (k_q == KW'(0));
    assign bus.dmap_oeop = ovld && (k_q == KW'(NW-1));
    assign bus.enc_odat  = ovld ? hdr_mem_q[rd_ptr_q] : '0;
    assign ovf_cnt       = ovf_q;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = cnt_q + {1'b0, wr} - {1'b0, pop};
        wr_ptr_d = wr_ptr_q ^ wr;
        rd_ptr_d = rd_ptr_q ^ pop;
        ovf_d    = drop ? sat_inc(ovf_q) : ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (cnt_d != 2'd0) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (hs) begin
                    k_d = pop ? KW'(0) : k_q + KW'(1);
                    if (pop) state_d = (cnt_d != 2'd0) ? ST_SEND : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Soft reset discards any in-flight beat and beats the same-cycle write/pop.
        if (cfg_rst) begin
            state_d  = ST_IDLE;
            k_d      = '0;
            cnt_d    = '0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            ovf_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            ovf_q    <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Payload storage needs no reset: it is only observed while cnt_q marks it valid.
    always_ff @(posedge clk) begin
        if (wr) begin
            beat_mem_q[wr_ptr_q] <= wr_beat;
            hdr_mem_q[wr_ptr_q]  <= bus.enc_idat;
        end
    end

endmodule
